// File: rtl/yolo_pkg.sv
// rtl/yolo_pkg.sv - shared tags, state encoding and detection record for the packer
package yolo_pkg;

  localparam int         OUT_W   = 24;
  localparam logic [7:0] HDR_TAG = 8'hA5;
  localparam logic [7:0] TRL_TAG = 8'h5A;

  typedef enum logic [1:0] {
    COLLECT,
    HEADER,
    DET,
    TRAILER
  } pk_state_t;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
    logic [7:0]  cls;
    logic [7:0]  conf;
  } det_rec_t;

endpackage

// File: rtl/det_buffer.sv
// rtl/det_buffer.sv - simple dual-port detection store, synchronous write, registered read
module det_buffer
  import yolo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  det_rec_t      wr_data,
  input  logic [AW-1:0] rd_addr,
  output det_rec_t      rd_data
);

  det_rec_t mem [DEPTH];

  // Read-during-write to the same address returns the old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/detection_packer.sv
// rtl/detection_packer.sv - buffers a frame of detections and streams it as header, records and checksum trailer
module detection_packer
  import yolo_pkg::*;
#(
  parameter int MAX_DET = 16,
  parameter int COORD_W = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               det_valid,
  output logic               det_ready,
  input  logic [COORD_W-1:0] det_x,
  input  logic [COORD_W-1:0] det_y,
  input  logic [COORD_W-1:0] det_w,
  input  logic [COORD_W-1:0] det_h,
  input  logic [7:0]         det_class,
  input  logic [7:0]         det_conf,
  input  logic               frame_end,
  output logic [OUT_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               overflow
);

  localparam int         AW    = (MAX_DET > 1) ? $clog2(MAX_DET) : 1;
  localparam logic [6:0] MAX_C = 7'(MAX_DET);

  pk_state_t        state, state_nxt;
  logic [6:0]       count, count_nxt;
  logic [6:0]       idx, idx_nxt;
  logic [1:0]       sub, sub_nxt;
  logic [7:0]       frame_id, fid_nxt;
  logic             ovf_bit, ovf_bit_nxt;
  logic             overflow_nxt;
  logic [15:0]      csum, csum_nxt, csum_sum;
  logic [OUT_W-1:0] data_nxt;
  logic             valid_nxt;
  det_rec_t         rec_hold, rec_nxt;

  det_rec_t         wr_rec, rd_rec, byp_rec, cur_rec;
  logic             wr_en, byp_valid, xfer;
  logic [AW-1:0]    wr_addr, rd_addr;

  assign wr_rec  = {det_x, det_y, det_w, det_h, det_class, det_conf};
  assign wr_en   = (state == COLLECT) && det_valid && (count < MAX_C);
  assign wr_addr = count[AW-1:0];
  // idx runs one past the record being emitted, so it may reach MAX_DET
  assign rd_addr = (idx < MAX_C) ? idx[AW-1:0] : '0;

  det_buffer #(
    .DEPTH (MAX_DET),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_rec),
    .rd_addr (rd_addr),
    .rd_data (rd_rec)
  );

  // A detection arriving with frame_end lands in the slot being read that same edge.
  assign cur_rec  = byp_valid ? byp_rec : rd_rec;
  assign xfer     = out_valid && out_ready;
  assign csum_sum = csum + out_data[15:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      count     <= '0;
      idx       <= '0;
      sub       <= '0;
      frame_id  <= '0;
      ovf_bit   <= 1'b0;
      overflow  <= 1'b0;
      csum      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      rec_hold  <= '0;
      byp_valid <= 1'b0;
      byp_rec   <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      idx       <= idx_nxt;
      sub       <= sub_nxt;
      frame_id  <= fid_nxt;
      ovf_bit   <= ovf_bit_nxt;
      overflow  <= overflow_nxt;
      csum      <= csum_nxt;
      out_data  <= data_nxt;
      out_valid <= valid_nxt;
      rec_hold  <= rec_nxt;
      byp_valid <= wr_en && (wr_addr == rd_addr);
      byp_rec   <= wr_rec;
    end
  end

  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    idx_nxt      = idx;
    sub_nxt      = sub;
    fid_nxt      = frame_id;
    ovf_bit_nxt  = ovf_bit;
    overflow_nxt = overflow;
    csum_nxt     = csum;
    data_nxt     = out_data;
    valid_nxt    = out_valid;
    rec_nxt      = rec_hold;
    det_ready    = 1'b0;

    case (state)
      COLLECT: begin
        det_ready = 1'b1;
        if (det_valid) begin
          if (count < MAX_C) begin
            count_nxt = count + 7'd1;
          end else begin
            ovf_bit_nxt  = 1'b1;
            overflow_nxt = 1'b1;
          end
        end
        if (frame_end) begin
          state_nxt = HEADER;
          data_nxt  = {HDR_TAG, frame_id, ovf_bit_nxt, count_nxt};
          valid_nxt = 1'b1;
          csum_nxt  = '0;
          idx_nxt   = '0;
          sub_nxt   = '0;
        end
      end

      HEADER: begin
        if (xfer) begin
          csum_nxt = csum_sum;
          if (count == 7'd0) begin
            state_nxt = TRAILER;
            data_nxt  = {TRL_TAG, csum_sum};
          end else begin
            state_nxt = DET;
            data_nxt  = {cur_rec.x, cur_rec.y};
            rec_nxt   = cur_rec;
            idx_nxt   = idx + 7'd1;
            sub_nxt   = 2'd0;
          end
        end
      end

      DET: begin
        if (xfer) begin
          csum_nxt = csum_sum;
          case (sub)
            2'd0: begin
              data_nxt = {rec_hold.w, rec_hold.h};
              sub_nxt  = 2'd1;
            end
            2'd1: begin
              data_nxt = {rec_hold.cls, rec_hold.conf, 1'b0, 7'(idx - 7'd1)};
              sub_nxt  = 2'd2;
            end
            default: begin
              if (idx == count) begin
                state_nxt = TRAILER;
                data_nxt  = {TRL_TAG, csum_sum};
              end else begin
                // Latching the record lets the next read start while W2/W3 drain.
                data_nxt = {cur_rec.x, cur_rec.y};
                rec_nxt  = cur_rec;
                idx_nxt  = idx + 7'd1;
                sub_nxt  = 2'd0;
              end
            end
          endcase
        end
      end

      TRAILER: begin
        if (xfer) begin
          state_nxt   = COLLECT;
          valid_nxt   = 1'b0;
          data_nxt    = '0;
          fid_nxt     = frame_id + 8'd1;
          count_nxt   = '0;
          ovf_bit_nxt = 1'b0;
          idx_nxt     = '0;
          sub_nxt     = '0;
          csum_nxt    = '0;
        end
      end

      default: begin
        state_nxt = COLLECT;
      end
    endcase
  end

endmodule
